// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the pipeline stage registers
package pipe_pkg;
    localparam int IDEX_CTRL_W = 16;
    localparam int IDEX_DATA_W = 320;
    localparam logic [IDEX_CTRL_W-1:0] BUBBLE_CTRL_DEF = '0;
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 5;
    localparam int CTRL_JALR     = 6;
    localparam int CTRL_JMP      = 7;
    localparam int CTRL_BRANCH   = 8;
    localparam int CTRL_ALUOP_LO = 9;
    localparam int CTRL_FUNCT3_LO = 11;
    localparam int CTRL_FUNCT7   = 14;
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one valid/ctrl/data slot with load, bubble substitute and clear
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic              bub,
    input  logic              clr,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);
    // clear kills the entry but leaves data untouched; load captures a payload
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            ctrl  <= BUBBLE_CTRL;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
            ctrl  <= BUBBLE_CTRL;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= bub ? BUBBLE_CTRL : d_ctrl;
            data  <= d_data;
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register with bubble, flush and optional skid entry
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W,
    parameter int SKID = 1,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  event_cnt
);
    logic accept, emit, head_load, head_clr, skid_load, skid_clr, evt;
    logic s_v;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;

    assign accept = in_valid & in_ready;
    assign emit = out_valid & out_ready;
    assign head_load = ~flush & ((accept & (~out_valid | emit)) | (emit & s_v));
    assign head_clr = flush | (emit & ~head_load);
    assign skid_load = ~flush & accept & out_valid & ~emit;
    assign skid_clr = flush | (emit & s_v);
    assign occupancy = {1'b0, out_valid} + {1'b0, s_v};
    assign evt = (accept & bubble) | (flush & (out_valid | s_v | accept));

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .BUBBLE_CTRL(BUBBLE_CTRL)) u_head (
        .clk(clk), .rstn(rstn), .load(head_load), .bub(s_v ? 1'b0 : bubble), .clr(head_clr),
        .d_ctrl(s_v ? s_ctrl : in_ctrl), .d_data(s_v ? s_data : in_data),
        .valid(out_valid), .ctrl(out_ctrl), .data(out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;
            pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .BUBBLE_CTRL(BUBBLE_CTRL)) u_skid (
                .clk(clk), .rstn(rstn), .load(skid_load), .bub(bubble), .clr(skid_clr),
                .d_ctrl(in_ctrl), .d_data(in_data),
                .valid(s_v), .ctrl(s_ctrl), .data(s_data)
            );
            // in_ready registers "skid will be empty next cycle"
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) in_ready_q <= 1'b1;
                else       in_ready_q <= ~(skid_load | (s_v & ~skid_clr));
            end
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign s_v = 1'b0;
            assign s_ctrl = BUBBLE_CTRL;
            assign s_data = '0;
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    // saturating count of accepted bubbles and effective flushes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                    event_cnt <= '0;
        else if (evt && ~&event_cnt)  event_cnt <= event_cnt + 1'b1;
    end
endmodule
